// File: rtl/mem_app_bridge_pkg.sv
// Shared types for the memory-domain bridge: arbiter command record,
// controller command encodings and bridge FSM states.
package mem_app_bridge_pkg;

    typedef struct packed {
        logic        read_not_write;
        logic [31:0] address;
        logic [31:0] length;
    } MemoryCommand;

    localparam logic [2:0] APP_CMD_WRITE = 3'b000;
    localparam logic [2:0] APP_CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        IDLE,
        WR_COLLECT,
        WR_ISSUE,
        RD_ACTIVE
    } bridge_state_t;

endpackage

// File: rtl/fifo_if.sv
// Valid/ready FIFO handshake bundle.
// in: consumer side (valid/data in, ready out); out: producer side.
interface FIFOInterface #(
    parameter int Nb = 32
);
    logic          valid;
    logic          ready;
    logic [Nb-1:0] data;

    modport in  (input valid, input data, output ready);
    modport out (output valid, output data, input ready);
endinterface

// File: rtl/fifo_sync.sv
// Single-clock show-ahead FIFO of 2**M entries of Nb bits.
// Ports: wr_en/din push, rd_en pops dout (head), empty/full/count status.
module fifo_sync #(
    parameter int Nb = 128,
    parameter int M  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [Nb-1:0] din,
    input  logic          rd_en,
    output logic [Nb-1:0] dout,
    output logic          empty,
    output logic          full,
    output logic [M:0]    count
);
    localparam int CW = M + 1;

    logic [Nb-1:0] mem [0:(1<<M)-1];
    logic [M-1:0]  wp;
    logic [M-1:0]  rp;
    logic          do_wr;
    logic          do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign dout  = mem[rp];
    assign empty = (count == '0);
    assign full  = (count == CW'(1 << M));

    always_ff @(posedge clk) begin
        if (do_wr) mem[wp] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_wr) wp <= wp + 1'b1;
            if (do_rd) rp <= rp + 1'b1;
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end
endmodule

// File: rtl/mem_app_bridge.sv
// Packs arbiter words into controller beats and unpacks read beats.
// Ports: mem_cmd/mem_write/mem_read FIFOs, app_* controller side, busy.
module mem_app_bridge
    import mem_app_bridge_pkg::*;
#(
    parameter int mem_width      = 32,
    parameter int app_data_width = 128,
    parameter int app_addr_width = 28,
    parameter int M_rd           = 4
) (
    input  logic                        clk_mem,
    input  logic                        reset,
    FIFOInterface.in                    mem_cmd,
    FIFOInterface.in                    mem_write,
    FIFOInterface.out                   mem_read,
    input  logic                        init_calib_complete,
    output logic                        app_en,
    input  logic                        app_rdy,
    output logic [2:0]                  app_cmd,
    output logic [app_addr_width-1:0]   app_addr,
    output logic [app_data_width-1:0]   app_wdf_data,
    output logic [app_data_width/8-1:0] app_wdf_mask,
    output logic                        app_wdf_wren,
    output logic                        app_wdf_end,
    input  logic                        app_wdf_rdy,
    input  logic [app_data_width-1:0]   app_rd_data,
    input  logic                        app_rd_data_valid,
    output logic                        busy
);
    localparam int LANES = app_data_width / mem_width;
    localparam int LW    = $clog2(LANES);
    localparam int BYTES = app_data_width / 8;
    localparam int BL    = $clog2(BYTES);
    localparam int LB    = mem_width / 8;
    localparam int OW    = M_rd + 1;
    localparam int DEPTH = 1 << M_rd;
    localparam logic [app_addr_width-1:0] STEP =
        app_addr_width'(BYTES);

    bridge_state_t state, state_n;
    MemoryCommand  cmd;

    logic [31:0] len_q, words_in, words_out;
    logic [31:0] beats, beats_issued;
    logic [LW-1:0] wr_lane, rd_lane;
    logic [app_data_width-1:0]   data_q;
    logic [app_data_width/8-1:0] mask_q;
    logic [app_addr_width-1:0]   addr_q;
    logic [2:0] cmd_q;
    logic en_q, wren_q, cmd_done, wdf_done;
    logic [OW-1:0] outstanding;

    logic [app_data_width-1:0] buf_dout;
    logic buf_empty, buf_full;
    logic [M_rd:0] buf_count;

    logic cmd_ready, cmd_fire;
    logic wr_ready, wr_fire, wr_last;
    logic cmd_ok, wdf_ok, beat_done;
    logic credit, rd_issue;
    logic rd_valid, rd_fire, rd_pop, rd_end;

    logic [LW-1:0]    fl;
    logic [32:0]      span;
    logic [31+BL:0]   base_full;

    assign cmd  = mem_cmd.data;
    assign fl   = cmd.address[LW-1:0];
    // beats touched = ceil((first_lane + L) / lanes), kept in 33 bits
    assign span = 33'(fl) + 33'(cmd.length) + 33'(LANES - 1);
    assign base_full = (32 + BL)'(cmd.address >> LW) << BL;

    assign cmd_ready = reset && (state == IDLE) && init_calib_complete;
    assign cmd_fire  = cmd_ready && mem_cmd.valid;

    assign wr_ready = (state == WR_COLLECT) && (words_in < len_q);
    assign wr_fire  = wr_ready && mem_write.valid;
    assign wr_last  = wr_fire &&
        ((wr_lane == LW'(LANES - 1)) || (words_in + 1 == len_q));

    assign cmd_ok    = cmd_done || (en_q && app_rdy);
    assign wdf_ok    = wdf_done || (wren_q && app_wdf_rdy);
    assign beat_done = (state == WR_ISSUE) && cmd_ok && wdf_ok;

    // Credit covers beats already committed to the controller plus beats
    // parked in the buffer, so returns can always be absorbed.
    assign credit = ((OW + 1)'(outstanding) + (OW + 1)'(buf_count))
                    < (OW + 1)'(DEPTH);
    assign rd_issue = (state == RD_ACTIVE) && (beats_issued < beats) &&
                      credit && (!en_q || app_rdy);

    assign rd_valid = (state == RD_ACTIVE) && !buf_empty &&
                      (words_out < len_q);
    assign rd_fire  = rd_valid && mem_read.ready;
    assign rd_end   = rd_fire && (words_out + 1 == len_q);
    assign rd_pop   = rd_fire &&
        ((rd_lane == LW'(LANES - 1)) || (words_out + 1 == len_q));

    assign mem_cmd.ready   = cmd_ready;
    assign mem_write.ready = wr_ready;
    assign mem_read.valid  = rd_valid;
    assign mem_read.data   = rd_valid ?
        buf_dout[rd_lane*mem_width +: mem_width] : '0;

    assign app_en       = en_q;
    assign app_cmd      = cmd_q;
    assign app_addr     = addr_q;
    assign app_wdf_data = data_q;
    assign app_wdf_mask = mask_q;
    assign app_wdf_wren = wren_q;
    assign app_wdf_end  = wren_q;
    assign busy         = (state != IDLE);

    fifo_sync #(
        .Nb (app_data_width),
        .M  (M_rd)
    ) u_rd_buf (
        .clk   (clk_mem),
        .rst_n (reset),
        .wr_en (app_rd_data_valid),
        .din   (app_rd_data),
        .rd_en (rd_pop),
        .dout  (buf_dout),
        .empty (buf_empty),
        .full  (buf_full),
        .count (buf_count)
    );

    always_ff @(posedge clk_mem or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (cmd_fire && cmd.length != 0)
                    state_n = cmd.read_not_write ? RD_ACTIVE : WR_COLLECT;
            end
            WR_COLLECT: begin
                if (wr_last) state_n = WR_ISSUE;
            end
            WR_ISSUE: begin
                if (beat_done)
                    state_n = (words_in == len_q) ? IDLE : WR_COLLECT;
            end
            RD_ACTIVE: begin
                if (rd_end) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_mem or negedge reset) begin
        if (!reset) begin
            len_q        <= '0;
            words_in     <= '0;
            words_out    <= '0;
            beats        <= '0;
            beats_issued <= '0;
            wr_lane      <= '0;
            rd_lane      <= '0;
            data_q       <= '0;
            mask_q       <= '0;
            addr_q       <= '0;
            cmd_q        <= '0;
            en_q         <= 1'b0;
            wren_q       <= 1'b0;
            cmd_done     <= 1'b0;
            wdf_done     <= 1'b0;
            outstanding  <= '0;
        end else begin
            if (cmd_fire) begin
                len_q        <= cmd.length;
                words_in     <= '0;
                words_out    <= '0;
                beats_issued <= '0;
                beats        <= 32'(span >> LW);
                wr_lane      <= fl;
                rd_lane      <= fl;
                addr_q       <= base_full[app_addr_width-1:0];
                cmd_q        <= cmd.read_not_write ?
                                APP_CMD_READ : APP_CMD_WRITE;
                data_q       <= '0;
                mask_q       <= '1;
            end
            if (wr_fire) begin
                data_q[wr_lane*mem_width +: mem_width] <= mem_write.data;
                mask_q[wr_lane*LB +: LB] <= '0;
                words_in <= words_in + 1;
                wr_lane  <= wr_lane + 1'b1;
            end
            if (wr_last) begin
                en_q     <= 1'b1;
                wren_q   <= 1'b1;
                cmd_done <= 1'b0;
                wdf_done <= 1'b0;
            end
            if (state == WR_ISSUE) begin
                if (en_q && app_rdy) begin
                    en_q     <= 1'b0;
                    cmd_done <= 1'b1;
                end
                if (wren_q && app_wdf_rdy) begin
                    wren_q   <= 1'b0;
                    wdf_done <= 1'b1;
                end
                if (beat_done) begin
                    addr_q <= addr_q + STEP;
                    data_q <= '0;
                    mask_q <= '1;
                end
            end
            if (state == RD_ACTIVE) begin
                // address advances on acceptance, ready for the next beat
                if (en_q && app_rdy) begin
                    en_q   <= rd_issue;
                    addr_q <= addr_q + STEP;
                end else if (rd_issue) begin
                    en_q <= 1'b1;
                end
                if (rd_issue) beats_issued <= beats_issued + 1;
                if (rd_fire) begin
                    words_out <= words_out + 1;
                    rd_lane   <= rd_lane + 1'b1;
                end
            end
            outstanding <= outstanding + OW'(rd_issue)
                           - OW'(app_rd_data_valid);
        end
    end

    always_ff @(posedge clk_mem) begin
        if (reset && app_rd_data_valid) begin
            rd_ovf: assert (!buf_full)
                else $error("read buffer overflow");
        end
    end
endmodule

// File: tb/tb_mem_app_bridge.sv
// Scoreboard bench for mem_app_bridge with a small controller model.
// Covers write packing, read unpacking, credits, calib gating, reset.
module tb_mem_app_bridge;
    import mem_app_bridge_pkg::*;

    typedef struct {
        logic [27:0]  addr;
        logic [127:0] data;
        logic [15:0]  mask;
    } wr_beat_t;

    typedef struct {
        logic [27:0] a;
        int          due;
    } rdreq_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n = 1'b0;
    logic         calib = 1'b0;
    logic         app_en, app_rdy, app_wdf_wren, app_wdf_end;
    logic         app_wdf_rdy, busy;
    logic         rd_dv = 1'b0;
    logic [2:0]   app_cmd;
    logic [27:0]  app_addr;
    logic [127:0] wdata;
    logic [127:0] rdata = '0;
    logic [15:0]  wmask;

    FIFOInterface #(.Nb(65)) cmd_if ();
    FIFOInterface #(.Nb(32)) wr_if ();
    FIFOInterface #(.Nb(32)) rd_if ();

    mem_app_bridge dut (
        .clk_mem             (clk),
        .reset               (rst_n),
        .mem_cmd             (cmd_if),
        .mem_write           (wr_if),
        .mem_read            (rd_if),
        .init_calib_complete (calib),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_cmd             (app_cmd),
        .app_addr            (app_addr),
        .app_wdf_data        (wdata),
        .app_wdf_mask        (wmask),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (rdata),
        .app_rd_data_valid   (rd_dv),
        .busy                (busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_rd_cmd = 0;
    bit rnd = 1'b0;
    bit rd_rnd = 1'b0;
    bit rd_hold = 1'b1;

    rdreq_t       rdq[$];
    logic [27:0]  wcmd_q[$];
    logic [143:0] wdf_q[$];
    logic [27:0]  rd_log[$];
    wr_beat_t     exp_wr[$];
    logic [31:0]  exp_rd[$];
    logic [31:0]  wq[$];

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] beat_of(input logic [27:0] a);
        logic [127:0] d;
        for (int i = 0; i < 4; i++) d[i*32 +: 32] = {a[15:0], 16'(i)};
        return d;
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] w);
        logic [31:0] b;
        b = (w >> 2) * 16;
        return {b[15:0], 16'(w % 4)};
    endfunction

    // controller model: sample accepts on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (app_en && app_rdy) begin
                if (app_cmd == APP_CMD_READ) begin
                    rdq.push_back('{app_addr, cyc + 3});
                    rd_log.push_back(app_addr);
                    n_rd_cmd++;
                end else begin
                    wcmd_q.push_back(app_addr);
                end
            end
            if (app_wdf_wren && app_wdf_rdy) begin
                check("wdf_end", 128'(app_wdf_end), 1);
                wdf_q.push_back({wmask, wdata});
            end
            if (wcmd_q.size() != 0 && wdf_q.size() != 0) begin
                logic [27:0]  a;
                logic [143:0] dm;
                a  = wcmd_q.pop_front();
                dm = wdf_q.pop_front();
                check("wr_exp_avail", 128'(exp_wr.size() != 0), 1);
                if (exp_wr.size() != 0) begin
                    wr_beat_t e;
                    e = exp_wr.pop_front();
                    check("wr_addr", 128'(a), 128'(e.addr));
                    check("wr_data", dm[127:0], e.data);
                    check("wr_mask", 128'(dm[143:128]), 128'(e.mask));
                end
            end
            if (rd_if.valid && rd_if.ready) begin
                check("rd_exp_avail", 128'(exp_rd.size() != 0), 1);
                if (exp_rd.size() != 0)
                    check("rd_word", 128'(rd_if.data),
                          128'(exp_rd.pop_front()));
            end
        end
    end

    // controller model: drive returns and readies after the rising edge
    always @(posedge clk) begin
        cyc++;
        #1;
        if (!rst_n) begin
            rdq.delete();
            rd_dv = 1'b0;
        end else if (rdq.size() != 0 && rdq[0].due <= cyc) begin
            rdreq_t r;
            r = rdq.pop_front();
            rd_dv = 1'b1;
            rdata = beat_of(r.a);
        end else begin
            rd_dv = 1'b0;
        end
        app_rdy     = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        app_wdf_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        rd_if.ready = rd_rnd ? 1'($urandom_range(0, 1)) : rd_hold;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input bit rnw, input logic [31:0] a,
                            input logic [31:0] l);
        int n = 0;
        cmd_if.data  = {rnw, a, l};
        cmd_if.valid = 1'b1;
        @(negedge clk);
        while (!cmd_if.ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept", 128'(cmd_if.ready), 1);
        tick();
        cmd_if.valid = 1'b0;
    endtask

    task automatic send_words();
        for (int k = 0; k < wq.size(); k++) begin
            int n = 0;
            wr_if.data  = wq[k];
            wr_if.valid = 1'b1;
            @(negedge clk);
            while (!wr_if.ready && n < 300) begin
                @(negedge clk);
                n++;
            end
            check("wr_accept", 128'(wr_if.ready), 1);
            tick();
        end
        wr_if.valid = 1'b0;
        @(negedge clk);
        check("wr_en_lat", 128'({app_en, app_wdf_wren}), 128'(2'b11));
    endtask

    task automatic push_wr_model(input logic [31:0] a);
        wr_beat_t b;
        int lane;
        logic [31:0] ba;
        lane = int'(a % 4);
        ba = (a >> 2) * 16;
        b.addr = ba[27:0];
        b.data = '0;
        b.mask = '1;
        for (int k = 0; k < wq.size(); k++) begin
            b.data[lane*32 +: 32] = wq[k];
            b.mask[lane*4 +: 4] = 4'h0;
            lane++;
            if (lane == 4 || k == wq.size() - 1) begin
                exp_wr.push_back(b);
                b.addr = b.addr + 28'd16;
                b.data = '0;
                b.mask = '1;
                lane = 0;
            end
        end
    endtask

    task automatic send_rd(input logic [31:0] a, input logic [31:0] l);
        for (int k = 0; k < int'(l); k++) exp_rd.push_back(word_of(a + k));
        send_cmd(1'b1, a, l);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 128'(busy), 0);
        tick();
    endtask

    initial begin
        int n0;
        int n;
        cmd_if.valid = 1'b0;
        cmd_if.data  = '0;
        wr_if.valid  = 1'b0;
        wr_if.data   = '0;
        repeat (2) tick();
        check("rst_ctl", 128'({cmd_if.ready, wr_if.ready, rd_if.valid,
              app_en, app_wdf_wren, app_wdf_end, busy}), 0);
        check("rst_addr", 128'({app_cmd, app_addr}), 0);
        check("rst_data", wdata, 0);
        check("rst_mask", 128'(wmask), 0);
        rst_n = 1'b1;
        tick();

        // no acceptance before calibration; L=0 consumed silently
        cmd_if.data  = {1'b0, 32'd7, 32'd0};
        cmd_if.valid = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        check("no_calib_ready", 128'(cmd_if.ready), 0);
        tick();
        calib = 1'b1;
        send_cmd(1'b0, 32'd7, 32'd0);
        repeat (3) tick();
        @(negedge clk);
        check("len0_busy", 128'(busy), 0);
        check("len0_no_traffic", 128'(wcmd_q.size() + wdf_q.size()), 0);
        tick();

        // single aligned beat
        exp_wr.push_back('{28'd0, {32'd4, 32'd3, 32'd2, 32'd1}, 16'h0000});
        send_cmd(1'b0, 32'd0, 32'd4);
        wq = '{32'd1, 32'd2, 32'd3, 32'd4};
        send_words();
        wait_idle("wr1_idle");

        // unaligned write spanning two beats
        exp_wr.push_back('{28'd16, {32'h12, 32'h11, 64'h0}, 16'h00FF});
        exp_wr.push_back('{28'd32, {32'h0, 32'h15, 32'h14, 32'h13},
                           16'hF000});
        send_cmd(1'b0, 32'd6, 32'd5);
        wq = '{32'h11, 32'h12, 32'h13, 32'h14, 32'h15};
        send_words();
        wait_idle("wr2_idle");
        check("wr2_drained", 128'(exp_wr.size()), 0);

        // unaligned read over three beats, first-word latency
        rd_log.delete();
        send_rd(32'd3, 32'd6);
        n = 0;
        @(negedge clk);
        while (!rd_dv && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rd_dv_seen", 128'(rd_dv), 1);
        @(negedge clk);
        check("rd_latency", 128'(rd_if.valid), 1);
        tick();
        wait_idle("rd1_idle");
        check("rd1_beats", 128'(rd_log.size()), 3);
        if (rd_log.size() == 3) begin
            check("rd1_a0", 128'(rd_log[0]), 0);
            check("rd1_a1", 128'(rd_log[1]), 16);
            check("rd1_a2", 128'(rd_log[2]), 32);
        end
        check("rd1_drained", 128'(exp_rd.size()), 0);

        // credit limit with the read side stalled
        rd_hold = 1'b0;
        n0 = n_rd_cmd;
        send_rd(32'd0, 32'd64);
        repeat (150) tick();
        @(negedge clk);
        check("credit_stop", 128'(n_rd_cmd - n0), 16);
        check("credit_busy", 128'(busy), 1);
        tick();
        rd_hold = 1'b1;
        wait_idle("rd64_idle");
        check("rd64_beats", 128'(n_rd_cmd - n0), 16);
        check("rd64_drained", 128'(exp_rd.size()), 0);

        // randomized handshakes on both sides
        rnd = 1'b1;
        rd_rnd = 1'b1;
        wq.delete();
        for (int k = 0; k < 10; k++) wq.push_back($urandom);
        push_wr_model(32'd13);
        send_cmd(1'b0, 32'd13, 32'd10);
        send_words();
        wait_idle("wr3_idle");
        send_rd(32'd5, 32'd10);
        wait_idle("rd3_idle");
        rnd = 1'b0;
        rd_rnd = 1'b0;
        tick();
        check("rnd_drained", 128'(exp_wr.size() + exp_rd.size()), 0);

        // asynchronous reset in the middle of a read
        rd_hold = 1'b0;
        send_rd(32'd0, 32'd40);
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_ctl", 128'({cmd_if.ready, wr_if.ready, rd_if.valid,
              app_en, app_wdf_wren, app_wdf_end, busy}), 0);
        check("rst_mid_addr", 128'({app_cmd, app_addr}), 0);
        check("rst_mid_data", wdata, 0);
        check("rst_mid_mask", 128'(wmask), 0);
        exp_rd.delete();
        exp_wr.delete();
        wcmd_q.delete();
        wdf_q.delete();
        rd_hold = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        wq = '{32'hA1, 32'hA2, 32'hA3};
        push_wr_model(32'd2);
        send_cmd(1'b0, 32'd2, 32'd3);
        send_words();
        wait_idle("wr4_idle");
        send_rd(32'd2, 32'd3);
        wait_idle("rd4_idle");
        tick();
        check("final_drained", 128'(exp_wr.size() + exp_rd.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
